// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

    // Controller states; RUN is the reset state.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } hazard_state_e;

    // Instruction word loaded into IF/ID when it is flushed.
    localparam logic [31:0] NOP_IR = 32'b0;

    // Width of the consecutive memory-wait counter.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step on inc, hold once all-ones is reached.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: load-use bubble, redirect
// flush, data-memory freeze with timeout, plus statistics counters.
//
// Handshake note: dmem_ready is sampled only while mem_access is high; a
// cycle with mem_access=1 and dmem_ready=0 freezes every pipeline register,
// and the access completes in the first cycle where both are high.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err,
    output logic [1:0]       dbg_state
);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic              freeze;
    logic              lu;
    logic [WAIT_W:0]   wait_inc;
    logic              pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic              ifid_flush_c, idex_flush_c;
    logic              stall_inc, flush_inc;

    assign freeze   = mem_access & ~dmem_ready;
    assign lu       = ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign wait_inc = {1'b0, wait_q} + {{WAIT_W{1'b0}}, 1'b1};

    // Priority resolution: ERROR > freeze > redirect > load-use > normal.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (state_q == ERROR) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
            state_d = ERROR;
        end else if (freeze) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
            if (state_q != MEM_WAIT) begin
                state_d = MEM_WAIT;
                wait_d  = {{(WAIT_W-1){1'b0}}, 1'b1};
            end else if (wait_inc > (WAIT_W+1)'(MEM_TIMEOUT)) begin
                state_d = ERROR;
                wait_d  = '0;
            end else begin
                wait_d  = wait_inc[WAIT_W-1:0];
            end
        end else begin
            wait_d = '0;
            if (ex_redirect) begin
                // Squashes IF/ID and ID/EX; any load-use on the ID instruction is moot.
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                flush_inc    = 1'b1;
                state_d      = RUN;
            end else if (lu && (state_q != LU_STALL)) begin
                // Hold PC and IF/ID, inject one bubble into ID/EX.
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
                stall_inc    = 1'b1;
                state_d      = LU_STALL;
            end else begin
                state_d = RUN;
            end
        end
        err_d = err_q | (state_d == ERROR);
    end

    // State, wait counter and sticky error registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced low during reset; a flush only acts with its enable.
    assign pc_en      = rst_n & pc_en_c;
    assign ifid_en    = rst_n & ifid_en_c;
    assign idex_en    = rst_n & idex_en_c;
    assign exmem_en   = rst_n & exmem_en_c;
    assign memwb_en   = rst_n & memwb_en_c;
    assign ifid_flush = ifid_en & ifid_flush_c;
    assign idex_flush = idex_en & idex_flush_c;
    assign err        = err_q;
    assign dbg_state  = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (4-bit counters to reach saturation).
module tb_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] C_NORM = 7'b11111_00;
    localparam logic [6:0] C_LU   = 7'b00111_01;
    localparam logic [6:0] C_RED  = 7'b11111_11;
    localparam logic [6:0] C_FRZ  = 7'b00000_00;

    logic             clock;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, ex_redirect, mem_access, dmem_ready;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             err;
    logic [1:0]       dbg_state;

    logic [6:0] exp_q[$];
    int         n_checks;
    int         n_pass;
    int         exp_stall;
    int         exp_flush;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // Clock and time limit.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b0;
    endtask

    // One cycle: queue the expected controls for the inputs already driven,
    // compare at the falling edge, then step past the rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp_ctrl);
        logic [6:0] e;
        exp_q.push_back(exp_ctrl);
        @(negedge clock);
        e = exp_q.pop_front();
        check(tag, {25'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
              {25'b0, e});
        @(posedge clock);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_stall"}, {28'b0, stall_cnt}, exp_stall);
        check({tag, "_flush"}, {28'b0, flush_cnt}, exp_flush);
    endtask

    initial begin
        logic mr, ur;
        logic [4:0] rd, rs, rt;
        logic exp_lu;
        n_checks = 0; n_pass = 0; exp_stall = 0; exp_flush = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset: everything held low.
        cyc("reset_ctrl", C_FRZ);
        check_cnts("reset");
        check("reset_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;

        cyc("idle", C_NORM);

        // Load-use on rs: one bubble, then normal even with lu still visible.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        cyc("lu_rs", C_LU);
        exp_stall++;
        cyc("lu_stall_state", C_NORM);
        check_cnts("lu_rs");
        idle_inputs();

        // ex_rd=0 never stalls; rt match ignored without id_uses_rt.
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        cyc("rd_zero", C_NORM);
        ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b0;
        cyc("rt_unused", C_NORM);
        id_uses_rt = 1'b1;
        cyc("lu_rt", C_LU);
        exp_stall++;
        idle_inputs();
        cyc("after_lu_rt", C_NORM);
        check_cnts("lu_rt");

        // Redirect beats load-use.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; ex_redirect = 1'b1;
        cyc("redirect_lu", C_RED);
        exp_flush++;
        idle_inputs();
        check_cnts("redirect_lu");

        // Three not-ready cycles freeze exactly three cycles.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("freeze3", C_FRZ);
        dmem_ready = 1'b1;
        cyc("freeze_done", C_NORM);
        idle_inputs();
        cyc("after_freeze", C_NORM);
        check("freeze_err", {31'b0, err}, 32'd0);

        // Freeze beats redirect; the redirect lands on the ready cycle.
        mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        cyc("freeze_redirect", C_FRZ);
        check_cnts("freeze_redirect");
        dmem_ready = 1'b1;
        cyc("redirect_after_ready", C_RED);
        exp_flush++;
        idle_inputs();
        check_cnts("redirect_after_ready");

        // Random load-use patterns from a small register pool.
        for (int i = 0; i < 10; i++) begin
            mr = 1'($urandom_range(0, 1));
            ur = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            exp_lu = mr && (rd != 5'd0) && ((rd == rs) || (ur && (rd == rt)));
            ex_mem_read = mr; id_uses_rt = ur; ex_rd = rd; id_rs = rs; id_rt = rt;
            cyc("rand_lu", exp_lu ? C_LU : C_NORM);
            if (exp_lu) exp_stall++;
            idle_inputs();
            cyc("rand_after", C_NORM);
        end
        check_cnts("rand");

        // Timeout: MEM_TIMEOUT+1 not-ready cycles reach ERROR.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) cyc("wait_long", C_FRZ);
        check("timeout_err", {31'b0, err}, 32'd1);
        dmem_ready = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) cyc("error_hold", C_FRZ);
        check("error_sticky", {31'b0, err}, 32'd1);
        idle_inputs();

        // Reset pulse clears err and counters.
        rst_n = 1'b0;
        exp_stall = 0; exp_flush = 0;
        cyc("reset2_ctrl", C_FRZ);
        rst_n = 1'b1;
        check("reset2_err", {31'b0, err}, 32'd0);
        check_cnts("reset2");
        cyc("reset2_run", C_NORM);

        // 20 redirects saturate a 4-bit flush counter at 15.
        ex_redirect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc("redirect_sat", C_RED);
            if (exp_flush < 15) exp_flush++;
        end
        idle_inputs();
        check_cnts("saturate");
        check("sat_value", {28'b0, flush_cnt}, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
